// File: rtl/gpmc_sram_top_if.sv
// GPMC control strobes between host (master) and the SRAM target (slave).
// The multiplexed AD bus stays a plain inout port on the target.
interface gpmc_sram_top_if;
    logic GPMC_CS;
    logic GPMC_ADV;
    logic GPMC_DIR;
    logic GPMC_OE;
    logic GPMC_BE0;
    logic GPMC_BE1;
    logic GPMC_WP;

    modport master (
        output GPMC_CS, GPMC_ADV, GPMC_DIR, GPMC_OE, GPMC_BE0, GPMC_BE1, GPMC_WP
    );

    modport slave (
        input GPMC_CS, GPMC_ADV, GPMC_DIR, GPMC_OE, GPMC_BE0, GPMC_BE1, GPMC_WP
    );
endinterface

// File: rtl/gpmc_sram_top.sv
// GPMC multiplexed-bus SRAM target: 2^ADDR_W x 16 storage, byte-lane writes,
// synchronous read-before-write, combinational AD drive.
module gpmc_sram_top #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic               GPMC_CLK,
    input  logic               GPMC_RST_N,
    inout  wire  [15:0]        GPMC_AD,
    gpmc_sram_top_if.slave     gpmc
);

    logic [15:0]       mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] addr;
    logic [15:0]       rdata;

    logic addr_phase;
    logic data_phase;
    logic wr_beat;
    logic drive_en;

    assign addr_phase = ~gpmc.GPMC_CS & ~gpmc.GPMC_ADV;
    assign data_phase = ~gpmc.GPMC_CS &  gpmc.GPMC_ADV;
    assign wr_beat    = data_phase & ~gpmc.GPMC_DIR & gpmc.GPMC_OE & ~gpmc.GPMC_WP
                      & (~gpmc.GPMC_BE0 | ~gpmc.GPMC_BE1);

    always_ff @(posedge GPMC_CLK or negedge GPMC_RST_N) begin
        if (!GPMC_RST_N) begin
            addr  <= '0;
            rdata <= '0;
        end else begin
            if (addr_phase)
                addr <= GPMC_AD[ADDR_W-1:0];
            if (data_phase)
                rdata <= mem[addr];
        end
    end

    // Storage has no reset; the reset term only blocks writes on edges while held.
    always_ff @(posedge GPMC_CLK) begin
        if (GPMC_RST_N && wr_beat) begin
            if (!gpmc.GPMC_BE0)
                mem[addr][7:0] <= GPMC_AD[7:0];
            if (!gpmc.GPMC_BE1)
                mem[addr][15:8] <= GPMC_AD[15:8];
        end
    end

    assign drive_en = GPMC_RST_N & ~gpmc.GPMC_CS & ~gpmc.GPMC_OE & gpmc.GPMC_DIR;
    assign GPMC_AD  = drive_en ? rdata : 'z;

endmodule

// File: tb/tb_gpmc_sram_top.sv
// Directed bench for gpmc_sram_top: stimulus queues expected AD values,
// a negedge monitor pops and compares them. A pullup makes a released bus read 0xFFFF.
module tb_gpmc_sram_top;
    logic        clk;
    logic        rst_n;
    wire  [15:0] ad;
    logic [15:0] ad_drv;
    logic        ad_en;
    logic        smp;

    localparam logic [15:0] REL = 16'hFFFF;

    string       exp_name [$];
    logic [15:0] exp_val  [$];
    int          n_cmp;
    int          n_bad;

    gpmc_sram_top_if bus ();

    gpmc_sram_top #(.ADDR_W(11)) dut (
        .GPMC_CLK   (clk),
        .GPMC_RST_N (rst_n),
        .GPMC_AD    (ad),
        .gpmc       (bus.slave)
    );

    assign ad = ad_en ? ad_drv : 'z;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup pu (ad[i]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (smp) begin
            n_cmp++;
            if (exp_val.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty: AD=%h with no expected entry", ad);
            end else begin
                string       nm;
                logic [15:0] ev;
                nm = exp_name.pop_front();
                ev = exp_val.pop_front();
                if (ad !== ev) begin
                    n_bad++;
                    $display("FAIL %s: AD got %h expected %h", nm, ad, ev);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pins(input logic cs, input logic adv, input logic dir, input logic oe,
                        input logic [1:0] be, input logic wp);
        bus.GPMC_CS  = cs;
        bus.GPMC_ADV = adv;
        bus.GPMC_DIR = dir;
        bus.GPMC_OE  = oe;
        bus.GPMC_BE0 = be[0];
        bus.GPMC_BE1 = be[1];
        bus.GPMC_WP  = wp;
    endtask

    // Address phase with write-like qualifiers held, so a latch-only edge is also exercised.
    task automatic addr_ph(input logic [15:0] a);
        pins(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        ad_drv = a; ad_en = 1'b1;
        cyc();
    endtask

    task automatic wr_ph(input logic [15:0] d, input logic [1:0] be, input logic wp);
        pins(1'b0, 1'b1, 1'b0, 1'b1, be, wp);
        ad_drv = d; ad_en = 1'b1;
        cyc();
    endtask

    task automatic nop_ph();
        pins(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        ad_en = 1'b0;
        cyc();
    endtask

    task automatic expect_ad(input string nm, input logic [15:0] ev);
        exp_name.push_back(nm);
        exp_val.push_back(ev);
        smp = 1'b1;
        cyc();
        smp = 1'b0;
    endtask

    task automatic rd_now(input string nm, input logic [15:0] ev);
        pins(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        ad_en = 1'b0;
        expect_ad(nm, ev);
    endtask

    task automatic read(input logic [15:0] a, input string nm, input logic [15:0] ev);
        addr_ph(a);
        nop_ph();
        rd_now(nm, ev);
    endtask

    task automatic write(input logic [15:0] a, input logic [15:0] d);
        addr_ph(a);
        wr_ph(d, 2'b00, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; smp = 1'b0;
        ad_en = 1'b0; ad_drv = '0;
        rst_n = 1'b0;
        pins(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        cyc();
        expect_ad("reset_release", REL);
        rst_n = 1'b1;
        expect_ad("rdata_after_reset", 16'h0000);

        write(16'h001F, 16'h1234);
        read(16'h001F, "write_read", 16'h1234);

        addr_ph(16'h001F);
        wr_ph(16'hABCD, 2'b10, 1'b0);
        read(16'h001F, "byte_lane_lo", 16'h12CD);

        addr_ph(16'h001F);
        wr_ph(16'h5A5A, 2'b11, 1'b0);
        nop_ph();
        rd_now("no_be_no_write", 16'h12CD);

        addr_ph(16'h001F);
        pins(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        ad_drv = 16'h7777; ad_en = 1'b1;
        cyc();
        read(16'h001F, "oe_low_no_write", 16'h12CD);

        write(16'h0010, 16'h0000);
        read(16'h0010, "wp_pre", 16'h0000);
        addr_ph(16'h0010);
        wr_ph(16'h5555, 2'b00, 1'b1);
        read(16'h0010, "write_protect", 16'h0000);

        write(16'h081F, 16'h00AA);
        read(16'h001F, "alias_read", 16'h00AA);

        addr_ph(16'h001F);
        wr_ph(16'h3C3C, 2'b00, 1'b0);
        rd_now("read_before_write", 16'h00AA);
        rd_now("after_write", 16'h3C3C);

        write(16'h0021, 16'h4242);
        read(16'h0021, "adv_beats_write", 16'h4242);

        addr_ph(16'h001F);
        pins(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        ad_drv = 16'h0010; ad_en = 1'b1;
        cyc();
        pins(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        ad_drv = 16'h9999;
        cyc();
        nop_ph();
        rd_now("cs_high_ignored", 16'h3C3C);

        addr_ph(16'h001F);
        nop_ph();
        addr_ph(16'h0021);
        nop_ph();
        rd_now("addr_override", 16'h4242);

        pins(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        ad_en = 1'b0;
        expect_ad("release_cs_high", REL);
        pins(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        expect_ad("release_oe_high", REL);

        write(16'h0000, 16'h0BEE);
        read(16'h0000, "mem0_pre", 16'h0BEE);
        rst_n = 1'b0;
        expect_ad("reset_mid_read", REL);
        addr_ph(16'h001F);
        wr_ph(16'h1111, 2'b00, 1'b0);
        pins(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        ad_en = 1'b0;
        #2;
        rst_n = 1'b1;
        expect_ad("rdata_cleared", 16'h0000);
        rd_now("addr_reset_mem_kept", 16'h0BEE);
        read(16'h001F, "first_addr_after_reset", 16'h3C3C);

        pins(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        cyc();
        cyc();
        if (exp_val.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d entries left, expected 0", exp_val.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gpmc_sram_top.md
GPMC_SRAM_TOP -- requirements
Module: gpmc_sram_top

Interface
REQ-001 The block SHALL expose GPMC_CLK, input, 1 bit: the single clock; all state SHALL be sampled on its rising edge.
REQ-002 The block SHALL expose GPMC_RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL expose GPMC_AD, inout, 16 bits: multiplexed address/data bus.
REQ-004 The block SHALL expose GPMC_CS, input, 1 bit: chip select, active-low.
REQ-005 The block SHALL expose GPMC_ADV, input, 1 bit: address valid/latch, active-low.
REQ-006 The block SHALL expose GPMC_DIR, input, 1 bit: 0 = host drives AD, 1 = host receives.
REQ-007 The block SHALL expose GPMC_OE, input, 1 bit: output enable, active-low.
REQ-008 The block SHALL expose GPMC_BE0, input, 1 bit: active-low byte enable for AD[7:0].
REQ-009 The block SHALL expose GPMC_BE1, input, 1 bit: active-low byte enable for AD[15:8].
REQ-010 The block SHALL expose GPMC_WP, input, 1 bit: write protect, active-high.
REQ-011 The block SHALL have parameter ADDR_W, default 11: internal word-address width, giving 2048 x 16 storage.

Function
REQ-012 An address phase occurs on a rising edge with CS=0 and ADV=0; the block SHALL latch AD[ADDR_W-1:0] into the address register.
REQ-013 AD bits above ADDR_W-1 SHALL be ignored, so addresses alias modulo 2^ADDR_W.
REQ-014 A data phase occurs on a rising edge with CS=0 and ADV=1.
REQ-015 A write beat occurs on a data-phase edge with DIR=0, OE=1, WP=0 and at least one BE low.
- Each byte lane whose BE is low SHALL be written from AD into mem[addr].
- Lanes whose BE is high SHALL be unchanged.
REQ-016 With all BE high, with WP=1, or with OE=0, a data-phase edge SHALL NOT modify memory.
REQ-017 On every data-phase edge the block SHALL register rdata <= mem[addr] (synchronous read, 1-cycle latency from the address phase).
- When a write beat and a read occur on the same edge, rdata SHALL return the old contents (read-before-write).
REQ-018 The block SHALL drive AD with rdata exactly when CS=0, OE=0 and DIR=1; otherwise AD SHALL be high-impedance.
REQ-019 Driving SHALL be combinational from CS, OE and DIR, so AD is released in the same cycle CS, OE or DIR deasserts.
REQ-020 The address register SHALL hold its value across data-phase edges; single-access only, no burst auto-increment.
REQ-021 A new address phase SHALL override the address register at any time, including mid-access.
REQ-022 When CS=1, the block SHALL ignore ADV, OE, BE and AD and SHALL change neither memory nor the address register.
REQ-023 If ADV=0 and a write condition hold on the same edge, only the address latch SHALL occur; no write.

Reset
REQ-024 While GPMC_RST_N=0, regardless of GPMC_CLK:
- address register SHALL be 0;
- rdata SHALL be 0;
- AD SHALL be high-impedance.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 Reset asserted mid-access SHALL abort the access; no write SHALL occur on any edge while reset is low.
REQ-027 The first address phase after reset release SHALL operate normally.

Verification
REQ-028 Write then read: address phase AD=0x001F; data edge DIR=0, OE=1, BE0=BE1=0, AD=0x1234; new address phase 0x001F; data edge; then OE=0, DIR=1 -> AD reads 0x1234.
REQ-029 Byte lane: preload 0x1234 at 0x001F, write AD=0xABCD with BE0=0, BE1=1 -> readback 0x12CD.
REQ-030 No write: address phase 0x001F, data edge with DIR=0, OE=1, BE0=BE1=1 -> memory unchanged; OE=0, DIR=1 two cycles later drives the prior contents.
REQ-031 Write protect: WP=1 write of 0x5555 to 0x0010 over 0x0000 -> readback 0x0000.
REQ-032 Aliasing: write 0x00AA to 0x081F -> read of 0x001F returns 0x00AA.
REQ-033 Release and reset:
- AD is high-impedance whenever CS=1 or OE=1.
- Asserting RST_N=0 during OE=0 releases AD immediately.
